vga_timing: RTL and testbench
=============================

# vga_timing

Parametrised VGA raster timing generator; next generation of the fixed 640x480 scan counter. Produces pixel position, active-video flag, programmable-polarity syncs, line/frame strobes and a pixel clock-enable from a faster system clock. Sits between the clock/reset block and any pixel source (pattern generator, framebuffer reader); all outputs are registered and glitch-free.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch, sync width, back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch, sync width, back porch (lines)
- HS_POL / VS_POL, 0 / 0, asserted sync level (0 = active-low)
- PIX_DIV, 1, clk cycles per pixel (>= 1)
- CW, 10, width of x/y; must hold H_TOTAL-1 and V_TOTAL-1 (elaboration error otherwise)
- FC_W, 8, frame counter width (only with VGA_TIMING_FRAME_CNT_EN)
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  run enable; low freezes all state
- pix_ce  out  1  high in the last clk of each pixel period; consumers sample x/y/draw here
- x  out  CW  horizontal position, 0..H_TOTAL-1
- y  out  CW  vertical position, 0..V_TOTAL-1
- draw  out  1  high iff x < H_ACTIVE and y < V_ACTIVE
- hs / vs  out  1  horizontal / vertical sync at configured polarity
- line_start  out  1  one-clk strobe, see Operation
- frame_start  out  1  one-clk strobe, see Operation
- frame_cnt  out  FC_W  completed-frame count (macro-gated)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider div counts 0..PIX_DIV-1 on clk while en=1; pix_ce = en && (div == PIX_DIV-1). PIX_DIV=1: pix_ce = en.
- On pix_ce: x increments; x == H_TOTAL-1 wraps to 0 and advances y; y == V_TOTAL-1 with x wrap returns to (0,0).
- hs asserted (level HS_POL) iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC; vs asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; otherwise inactive (~POL).
- draw, hs, vs decoded from next-state x/y and registered, so they change in the same clk edge as x/y; no combinational output decode.
- line_start: high for exactly the first clk in which x==0 is presented after a wrap. frame_start: same, when (x,y)==(0,0) after a frame wrap; coincides with a line_start.
- en=0: div, x, y, all outputs hold; pix_ce low; strobes already high drop after one clk and are not re-issued.

## Timing
- Reset (async assert, immediate): div=0, x=0, y=0, draw=1, hs=~HS_POL, vs=~VS_POL, line_start=0, frame_start=0, frame_cnt=0, pix_ce = (PIX_DIV==1) && en.
- No strobe for the post-reset (0,0); first frame_start after H_TOTAL*V_TOTAL*PIX_DIV enabled clks.
- x/y/draw/hs/vs latency: 1 clk after the pix_ce cycle.
- Period: line_start every H_TOTAL*PIX_DIV enabled clks; frame_start every H_TOTAL*V_TOTAL*PIX_DIV.
- Reset mid-frame: all state to reset values asynchronously; restart from (0,0) on first enabled clk after release.
- Reset release is synchronised externally; block requires deassertion synchronous to clk.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: frame_cnt port present; increments in the cycle frame_start is asserted; wraps 2^FC_W-1 -> 0.
- Undefined: frame_cnt port and counter absent; all other behaviour identical.

## Structure
- Package vga_timing_pkg: mode constants (640x480@60, 800x600@60 porch/sync/polarity sets), total and sync-window helper functions, min-CW function.
- Sub-module vga_axis_counter, instantiated twice (horizontal, vertical): wrap counter with step enable, ACTIVE/FP/SYNC boundaries, registered active/sync/wrap outputs.

## Test plan
- Defaults, PIX_DIV=1: hs low exactly x=656..751; vs low y=490..491; line_start every 800 clks; frame_start every 420000 clks.
- PIX_DIV=4: pix_ce every 4th clk; x steps 0->1 on clk 4 after reset release; line_start period 3200.
- HS_POL=1, VS_POL=1, 800x600 set (40/128/88, 1/4/23): hs high x=840..967; vs high y=601..604; draw low from x=800.
- en low at (x=100, y=10) for 50 clks: outputs frozen, no pix_ce; resume at x=101.
- rst asserted mid-line at (x=700, y=300): outputs immediately reset values; after release x=1 next clk, no frame_start until a full frame.
- Macro defined, FC_W=2: frame_cnt 0,1,2,3,0 across five frames, incrementing with frame_start.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared mode constants and geometry helpers for the VGA raster timing generator.
// Used by vga_timing and vga_axis_counter (VGA_TIMING_FRAME_CNT_EN is handled in vga_timing).
package vga_timing_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
        logic        pol;
    } axis_mode_t;

    localparam axis_mode_t MODE_640X480_H = '{active: 640, fp: 16, sync: 96,  bp: 48, pol: 1'b0};
    localparam axis_mode_t MODE_640X480_V = '{active: 480, fp: 10, sync: 2,   bp: 33, pol: 1'b0};
    localparam axis_mode_t MODE_800X600_H = '{active: 800, fp: 40, sync: 128, bp: 88, pol: 1'b1};
    localparam axis_mode_t MODE_800X600_V = '{active: 600, fp: 1,  sync: 4,   bp: 23, pol: 1'b1};

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int sync_start(input int active, input int fp);
        return active + fp;
    endfunction

    // Exclusive upper bound of the sync window.
    function automatic int sync_end(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

    // Bits needed to hold the value n (at least one).
    function automatic int min_cw(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((n >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered sync and wrap strobe,
// plus the next-state active flag so the parent can register a combined draw.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    parameter int CW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step_i,
    output logic          last_o,
    output logic [CW-1:0] pos_o,
    output logic          active_nx_o,
    output logic          sync_o,
    output logic          wrap_o
);

    localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SS    = sync_start(ACTIVE, FP);
    localparam int SE    = sync_end(ACTIVE, FP, SYNC);

    logic [CW-1:0] pos_q, pos_d;
    logic          sync_q, sync_d;
    logic          wrap_q, wrap_d;

    assign last_o = (pos_q == CW'(TOTAL - 1));

    // Outputs are decoded from the next position so they move on the same edge as pos.
    always_comb begin
        pos_d  = pos_q;
        wrap_d = 1'b0;
        if (step_i) begin
            if (last_o) begin
                pos_d  = '0;
                wrap_d = 1'b1;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end
        active_nx_o = (int'(pos_d) < ACTIVE);
        sync_d      = ((int'(pos_d) >= SS) && (int'(pos_d) < SE)) ? POL : ~POL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q  <= '0;
            sync_q <= ~POL;
            wrap_q <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            sync_q <= sync_d;
            wrap_q <= wrap_d;
        end
    end

    assign pos_o  = pos_q;
    assign sync_o = sync_q;
    assign wrap_o = wrap_q;

endmodule

// File: rtl/vga_timing.sv
// Parametrised VGA raster timing generator with pixel clock-enable divider.
// Define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output and counter.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int PIX_DIV  = 1,
    parameter int CW       = 10
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    parameter int FC_W     = 8
`endif
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_ce,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          draw,
    output logic          hs,
    output logic          vs,
    output logic          line_start,
    output logic          frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [FC_W-1:0] frame_cnt
`endif
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int DIV_W   = (PIX_DIV > 1) ? min_cw(PIX_DIV - 1) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    if ((CW < min_cw(H_TOTAL - 1)) || (CW < min_cw(V_TOTAL - 1))) begin : g_cw_too_narrow
        $error("vga_timing: CW cannot hold H_TOTAL-1 / V_TOTAL-1");
    end
    if (PIX_DIV < 1) begin : g_bad_pix_div
        $error("vga_timing: PIX_DIV must be at least 1");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             h_last, v_last, v_step;
    logic             h_act_nx, v_act_nx;
    logic             draw_q, draw_d;

    always_comb begin
        div_d = div_q;
        if (en) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end

    assign pix_ce = en && (div_q == DIV_LAST);
    assign v_step = pix_ce & h_last;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .CW(CW)
    ) u_h (
        .clk        (clk),
        .rst        (rst),
        .step_i     (pix_ce),
        .last_o     (h_last),
        .pos_o      (x),
        .active_nx_o(h_act_nx),
        .sync_o     (hs),
        .wrap_o     (line_start)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .CW(CW)
    ) u_v (
        .clk        (clk),
        .rst        (rst),
        .step_i     (v_step),
        .last_o     (v_last),
        .pos_o      (y),
        .active_nx_o(v_act_nx),
        .sync_o     (vs),
        .wrap_o     (frame_start)
    );

    assign draw_d = h_act_nx & v_act_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) draw_q <= 1'b1;
        else     draw_q <= draw_d;
    end

    assign draw = draw_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [FC_W-1:0] fc_q, fc_d;

    // Counts on the same edge that raises frame_start.
    assign fc_d = (v_step & v_last) ? fc_q + 1'b1 : fc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) fc_q <= '0;
        else     fc_q <= fc_d;
    end

    assign frame_cnt = fc_q;
`else
    logic unused_v_last;
    assign unused_v_last = v_last;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default 640x480 instance and a tiny PIX_DIV=4 positive-sync
// instance share clk/rst/en; an arithmetic raster model is compared every cycle.
module tb_vga_timing;

    logic clk;
    logic rst;
    logic en;

    logic       pce0, draw0, hs0, vs0, ls0, fs0;
    logic [9:0] x0, y0;
    logic       pce1, draw1, hs1, vs1, ls1, fs1;
    logic [4:0] x1, y1;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] fc0;
    logic [1:0] fc1;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: enabled clocks since reset, and whether the last edge advanced.
    int n   = 0;
    bit adv = 1'b0;

    typedef struct packed {
        int x;
        int y;
        bit pce;
        bit draw;
        bit hs;
        bit vs;
        bit ls;
        bit fs;
        int fc;
    } exp_t;

    vga_timing u0 (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce0), .x(x0), .y(y0), .draw(draw0),
        .hs(hs0), .vs(vs0), .line_start(ls0), .frame_start(fs0)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc0)
`endif
    );

    vga_timing #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIX_DIV(4), .CW(5)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .FC_W(2)
`endif
    ) u1 (
        .clk(clk), .rst(rst), .en(en), .pix_ce(pce1), .x(x1), .y(y1), .draw(draw1),
        .hs(hs1), .vs(vs1), .line_start(ls1), .frame_start(fs1)
`ifdef VGA_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t model(input int ha, input int hf, input int hsw, input int hb,
                                   input int va, input int vf, input int vsw, input int vb,
                                   input int pd, input bit hp, input bit vp, input int fcw,
                                   input int cnt, input bit adv_i, input bit en_i);
        exp_t e;
        int ht, vt, pix, dv;
        ht     = ha + hf + hsw + hb;
        vt     = va + vf + vsw + vb;
        pix    = cnt / pd;
        dv     = cnt % pd;
        e.x    = pix % ht;
        e.y    = (pix / ht) % vt;
        e.pce  = en_i && (dv == pd - 1);
        e.draw = (e.x < ha) && (e.y < va);
        e.hs   = (e.x >= ha + hf && e.x < ha + hf + hsw) ? hp : ~hp;
        e.vs   = (e.y >= va + vf && e.y < va + vf + vsw) ? vp : ~vp;
        e.ls   = adv_i && (dv == 0) && (e.x == 0) && (pix > 0);
        e.fs   = e.ls && (e.y == 0);
        e.fc   = (pix / (ht * vt)) % (1 << fcw);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t, n=%0d)", nm, act, req, $time, n);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            n   <= 0;
            adv <= 1'b0;
        end else if (en) begin
            n   <= n + 1;
            adv <= 1'b1;
        end else begin
            adv <= 1'b0;
        end
    end

    // Every-cycle comparison against the model, sampled 1 time unit after the edge.
    always @(posedge clk) begin
        exp_t e0, e1;
        #1;
        e0 = model(640, 16, 96, 48, 480, 10, 2, 33, 1, 1'b0, 1'b0, 8, n, adv, en);
        e1 = model(10, 2, 3, 1, 6, 1, 2, 1, 4, 1'b1, 1'b1, 2, n, adv, en);
        chk("u0.x", 32'(x0), e0.x);
        chk("u0.y", 32'(y0), e0.y);
        chk("u0.pix_ce", 32'(pce0), 32'(e0.pce));
        chk("u0.draw", 32'(draw0), 32'(e0.draw));
        chk("u0.hs", 32'(hs0), 32'(e0.hs));
        chk("u0.vs", 32'(vs0), 32'(e0.vs));
        chk("u0.line_start", 32'(ls0), 32'(e0.ls));
        chk("u0.frame_start", 32'(fs0), 32'(e0.fs));
        chk("u1.x", 32'(x1), e1.x);
        chk("u1.y", 32'(y1), e1.y);
        chk("u1.pix_ce", 32'(pce1), 32'(e1.pce));
        chk("u1.draw", 32'(draw1), 32'(e1.draw));
        chk("u1.hs", 32'(hs1), 32'(e1.hs));
        chk("u1.vs", 32'(vs1), 32'(e1.vs));
        chk("u1.line_start", 32'(ls1), 32'(e1.ls));
        chk("u1.frame_start", 32'(fs1), 32'(e1.fs));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("u0.frame_cnt", 32'(fc0), e0.fc);
        chk("u1.frame_cnt", 32'(fc1), e1.fc);
`endif
    end

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (n != target) begin
            checks++;
            errors++;
            $display("FAIL run_to: model count %0d, required %0d", n, target);
        end
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst.u0.x", 32'(x0), 0);
        chk("rst.u0.draw", 32'(draw0), 1);
        chk("rst.u0.hs", 32'(hs0), 1);
        chk("rst.u0.vs", 32'(vs0), 1);
        chk("rst.u0.line_start", 32'(ls0), 0);
        chk("rst.u0.pix_ce", 32'(pce0), 1);
        chk("rst.u1.pix_ce", 32'(pce1), 0);
        chk("rst.u1.hs", 32'(hs1), 0);
        chk("rst.u1.vs", 32'(vs1), 0);

        rst = 1'b0;
        @(negedge clk);
        chk("rel.u0.x@1", 32'(x0), 1);
        chk("rel.u1.x@1", 32'(x1), 0);
        run_to(3);
        chk("u1.pix_ce@3", 32'(pce1), 1);
        chk("u1.x@3", 32'(x1), 0);
        run_to(4);
        chk("u1.x@4", 32'(x1), 1);

        run_to(639);  chk("u0.draw@639", 32'(draw0), 1);
        run_to(640);  chk("u0.draw@640", 32'(draw0), 0);
        run_to(655);  chk("u0.hs@655", 32'(hs0), 1);
        run_to(656);  chk("u0.hs@656", 32'(hs0), 0);
        run_to(751);  chk("u0.hs@751", 32'(hs0), 0);
        run_to(752);  chk("u0.hs@752", 32'(hs0), 1);
        run_to(799);  chk("u0.ls@799", 32'(ls0), 0);
        run_to(800);
        chk("u0.ls@800", 32'(ls0), 1);
        chk("u0.x@800", 32'(x0), 0);
        chk("u0.y@800", 32'(y0), 1);
        run_to(801);  chk("u0.ls@801", 32'(ls0), 0);

        // Freeze at (100,10) for 50 clocks.
        run_to(8100);
        chk("frz.u0.x", 32'(x0), 100);
        chk("frz.u0.y", 32'(y0), 10);
        en = 1'b0;
        repeat (50) @(negedge clk);
        chk("frz.u0.x.after", 32'(x0), 100);
        chk("frz.u0.pix_ce", 32'(pce0), 0);
        en = 1'b1;
        @(negedge clk);
        chk("frz.u0.x.resume", 32'(x0), 101);

        // Disable while line_start is high: strobe drops, position holds.
        run_to(8800);
        chk("hold.u0.ls", 32'(ls0), 1);
        en = 1'b0;
        @(negedge clk);
        chk("hold.u0.ls.drop", 32'(ls0), 0);
        chk("hold.u0.x", 32'(x0), 0);
        en = 1'b1;

        run_to(8960);
        chk("u1.fs@8960", 32'(fs1), 1);
        chk("u1.y@8960", 32'(y1), 0);
        run_to(9007); chk("u1.hs@x11", 32'(hs1), 0);
        run_to(9008); chk("u1.hs@x12", 32'(hs1), 1);

        // Asynchronous reset mid-line.
        #2 rst = 1'b1;
        #1;
        chk("arst.u0.x", 32'(x0), 0);
        chk("arst.u0.y", 32'(y0), 0);
        chk("arst.u0.draw", 32'(draw0), 1);
        chk("arst.u0.hs", 32'(hs0), 1);
        chk("arst.u1.x", 32'(x1), 0);
        chk("arst.u1.hs", 32'(hs1), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst.u0.x.next", 32'(x0), 1);
        chk("arst.u0.fs", 32'(fs0), 0);

        run_to(447); chk("u1.vs@y6", 32'(vs1), 0);
        run_to(448); chk("u1.vs@y7", 32'(vs1), 1);
        run_to(639); chk("u1.fs@639", 32'(fs1), 0);
        run_to(640); chk("u1.fs@640", 32'(fs1), 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
        run_to(1920); chk("u1.fc@3frames", 32'(fc1), 3);
        run_to(3200); chk("u1.fc@5frames", 32'(fc1), 1);
`endif
        run_to(3210);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
